// File: rtl/coin_bank.sv
// Per-level coin manager: scans coins against the player box once per frame,
// tracks collected/checkpoint flags and drives the coin pixel mask and counts.
module coin_bank #(
   parameter int unsigned NUM_COINS = 4,
   parameter int unsigned COIN_SIZE = 3
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       frame_clk,
   input  logic [1:0] Level,
   input  logic       Player_Death,
   input  logic       Checkpoint,
   input  logic [9:0] PlayerX,
   input  logic [9:0] PlayerY,
   input  logic [9:0] PlayerS,
   input  logic [9:0] DrawX,
   input  logic [9:0] DrawY,
   output logic       Coin_On,
   output logic [3:0] CoinCount,
   output logic [3:0] CoinsTotal,
   output logic       AllCollected,
   output logic       Collect_Pulse
);

   localparam int unsigned PIX_W = 10;
   localparam int unsigned DIF_W = 11;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned IDX_W = $clog2(NUM_COINS);

   typedef enum logic {IDLE, SCAN} state_e;

   state_e                 state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [NUM_COINS-1:0]   collected_q, collected_d;
   logic [NUM_COINS-1:0]   saved_q, saved_d;
   logic                   frame_q;
   logic [1:0]             level_q;
   logic                   pulse_q, pulse_d;

   logic [PIX_W-1:0]       coin_x [NUM_COINS];
   logic [PIX_W-1:0]       coin_y [NUM_COINS];
   logic [NUM_COINS-1:0]   coin_en;
   logic [DIF_W-1:0]       hit_lim;
   logic                   hit;
   logic                   frame_rise;

   function automatic logic [DIF_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                  input logic [PIX_W-1:0] b);
      return (a >= b) ? DIF_W'(a - b) : DIF_W'(b - a);
   endfunction

   // Coin placement table; slots past the level's count stay disabled
   always_comb begin
      for (int i = 0; i < int'(NUM_COINS); i++) begin
         coin_x[i] = '0;
         coin_y[i] = '0;
      end
      coin_en = '0;
      case (Level)
         2'd1: begin
            coin_x[0] = 10'd320; coin_y[0] = 10'd240; coin_en[0] = 1'b1;
         end
         2'd2: begin
            coin_x[0] = 10'd320; coin_y[0] = 10'd240; coin_en[0] = 1'b1;
            coin_x[1] = 10'd200; coin_y[1] = 10'd240; coin_en[1] = 1'b1;
         end
         2'd3: begin
            coin_x[0] = 10'd290; coin_y[0] = 10'd190; coin_en[0] = 1'b1;
            coin_x[1] = 10'd350; coin_y[1] = 10'd190; coin_en[1] = 1'b1;
            coin_x[2] = 10'd290; coin_y[2] = 10'd290; coin_en[2] = 1'b1;
            coin_x[3] = 10'd350; coin_y[3] = 10'd290; coin_en[3] = 1'b1;
         end
         default: ;
      endcase
   end

   assign frame_rise = frame_clk & ~frame_q;
   assign hit_lim    = DIF_W'(PlayerS) + DIF_W'(COIN_SIZE);
   assign hit        = (abs_diff(PlayerX, coin_x[idx_q]) < hit_lim) &&
                       (abs_diff(PlayerY, coin_y[idx_q]) < hit_lim);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         collected_q <= '0;
         saved_q     <= '0;
         frame_q     <= 1'b0;
         level_q     <= '0;
         pulse_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         collected_q <= collected_d;
         saved_q     <= saved_d;
         frame_q     <= frame_clk;
         level_q     <= Level;
         pulse_q     <= pulse_d;
      end
   end

   // Level change beats death beats checkpoint beats the scan step
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      collected_d = collected_q;
      saved_d     = saved_q;
      pulse_d     = 1'b0;
      if (Level != level_q) begin
         collected_d = '0;
         saved_d     = '0;
         state_d     = IDLE;
         idx_d       = '0;
      end else if (Player_Death) begin
         collected_d = saved_q;
         state_d     = IDLE;
         idx_d       = '0;
      end else begin
         if (Checkpoint) saved_d = collected_q;
         case (state_q)
            IDLE: begin
               if (frame_rise) begin
                  state_d = SCAN;
                  idx_d   = '0;
               end
            end
            SCAN: begin
               if (coin_en[idx_q] && !collected_q[idx_q] && hit) begin
                  collected_d[idx_q] = 1'b1;
                  pulse_d            = 1'b1;
               end
               if (idx_q == IDX_W'(NUM_COINS - 1)) begin
                  state_d = IDLE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      Coin_On    = 1'b0;
      CoinCount  = '0;
      CoinsTotal = '0;
      for (int i = 0; i < int'(NUM_COINS); i++) begin
         if (coin_en[i] && !collected_q[i] &&
             abs_diff(DrawX, coin_x[i]) <= DIF_W'(COIN_SIZE) &&
             abs_diff(DrawY, coin_y[i]) <= DIF_W'(COIN_SIZE))
            Coin_On = 1'b1;
         CoinCount  = CoinCount + CNT_W'(collected_q[i] & coin_en[i]);
         CoinsTotal = CoinsTotal + CNT_W'(coin_en[i]);
      end
   end

   assign AllCollected  = (CoinsTotal != '0) && (CoinCount == CoinsTotal);
   assign Collect_Pulse = pulse_q;

endmodule
